// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Width of a counter that must hold the value bin_w.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock.
// Optional leading-zero blank mask enabled by BCD_LEADING_ZERO_BLANK_EN.
//
// state | meaning
// IDLE  | ready, waiting for start
// OP    | adjust digits and shift one bit per cycle
// DONE  | one-cycle done_tick, bcd already updated
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W      = 20,
  parameter int BCD_DIGITS = 7
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    ready,
  output logic                    done_tick,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic [BCD_DIGITS-1:0]   blank
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int DIG_W = 4 * BCD_DIGITS;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [DIG_W-1:0]   dig_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   bcd_q, bcd_d;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (dig_q[4*g +: 4]),
      .digit_o (dig_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          dig_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = OP;
        end
      end
      OP: begin
        // The top digit's MSB falls off; the digit count guarantees it stays 0.
        {dig_d, shift_d} = {dig_adj[DIG_W-2:0], shift_q, 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = {dig_adj[DIG_W-2:0], shift_q[BIN_W-1]};
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign done_tick = (state_q == DONE);
  assign bcd       = bcd_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic zero_run;
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = BCD_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (bcd_q[4*k +: 4] == 4'd0);
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter: turns the 20-bit polynomial result into 7 packed BCD digits for the seven-segment display driver.
- Sits directly downstream of the polynomial solver: its done_tick drives start, its 20-bit result drives bin.
- Converts one bit per clock through a three-state FSM with a start/done_tick handshake.
- Holds the last converted result stable until the next conversion completes.

Parameters:
- BIN_W, 20, binary input width.
- BCD_DIGITS, 7, number of BCD output digits. Must satisfy 10^BCD_DIGITS > 2^BIN_W; the default covers 0..1,048,575.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in idle.
- bin  input  BIN_W  binary value; latched on the accepted start.
- ready  output  1  high while in idle (combinational from state).
- done_tick  output  1  one-cycle pulse: conversion complete, bcd updated.
- bcd  output  4*BCD_DIGITS  packed digits; digit k occupies bits [4k+3:4k]; digit 0 is least significant.
- blank  output  BCD_DIGITS  leading-zero blank mask; bit k=1 means suppress digit k (see Optional Feature).

Behaviour:
- Clock and reset are fixed: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: state=idle; working shift, digit and count registers = 0; bcd hold register = 0; done_tick=0; ready=1.
- Reset asserted mid-conversion aborts immediately. No done_tick is produced, and bcd returns to 0.
- FSM states are idle, op and done.
- idle:
  - ready=1.
  - If start=1: load the shift register with bin, clear the working digits, set count=BIN_W, go to op.
  - If start=0: remain in idle.
- op: each cycle, for every working digit:
  - digit >= 5: add 3 (4-bit, no carry out);
  - then shift {digits, shift register} left by one, so the shift register MSB enters digit 0 LSB;
  - then decrement count.
- op exit: on the cycle count reaches 0, meaning the BIN_W-th shift, copy the post-shift digits into the bcd hold register and go to done.
- done: done_tick=1 for exactly one cycle, then go to idle.
- Latency: with start sampled at edge 0, shifts occur at edges 1..BIN_W. bcd updates at edge BIN_W, and done_tick is high in the following cycle. Total is BIN_W+1 cycles to done_tick and BIN_W+2 cycles to ready again.
- start while in op or done is ignored. No queuing, and bin is not re-sampled.
- start in the same cycle the FSM returns to idle is not seen; the first acceptable start is while ready=1.
- bcd changes only at conversion completion and is never visible mid-conversion.
- The count register is $clog2(BIN_W+1) bits wide; no other wrap-around is possible.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined: blank is combinational from bcd. Bit k=1 if and only if digits BCD_DIGITS-1..k are all zero and k != 0; digit 0 is never blanked.
  - Reset and value 0 give blank = 7'b1111110.
- Undefined: blank is tied to all zeros.
- bcd and all timing are identical in both builds.

Decomposition:
- Shared package bin2bcd_pkg holds:
  - state enum {IDLE, OP, DONE};
  - BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3;
  - a function computing the count width from BIN_W.
- Sub-module bcd_digit_adj: 4-bit combinational add-3-if->=5. Instantiated BCD_DIGITS times with a generate loop.

Test Plan:
- Reset, then bin=52 (solver h(3)) with one start pulse:
  - done_tick occurs exactly 21 cycles after start;
  - bcd=28'h0000052;
  - ready returns 1 the next cycle.
- bin=1048575: bcd=28'h1048575. bin=0: bcd=28'h0000000, with done_tick still produced.
- start re-pulsed at cycle 5 of a conversion with a different bin:
  - ignored;
  - only one done_tick;
  - result matches the first bin.
- reset_n pulsed low at cycle 10 of a conversion of 999999:
  - no done_tick;
  - bcd=0 and ready=1 right after reset;
  - a fresh conversion of 999999 gives 28'h0999999.
- Back-to-back: the solver's done_tick drives start for values 1, 5, 16, 52. The four done_ticks yield 28'h0000001, 28'h0000005, 28'h0000016, 28'h0000052.
- With BCD_LEADING_ZERO_BLANK_EN:
  - 52 gives blank=7'b1111100;
  - 1048575 gives 7'b0000000;
  - 0 gives 7'b1111110.
  - Without the macro, blank is 0 for all values.
